// File: rtl/tile_pkg.sv
// Shared constants, tile ID encoding and helpers for the tile pixel fetch path.
// Optional grid overlay build macro: TILE_GRID_OVERLAY_EN.
package tile_pkg;

  localparam int TILE_W   = 24;
  localparam int MAP_COLS = 27;
  localparam int MAP_ROWS = 20;

  localparam int ADDR_W = 10;
  localparam int POS_W  = 5;
  localparam int RGB_W  = 12;

  localparam logic [RGB_W-1:0] SKY_RGB   = 12'h6BF;
  localparam logic [RGB_W-1:0] KEY_RGB   = 12'hF0F;
  localparam logic [RGB_W-1:0] GRID_RGB  = 12'hFFF;
  localparam logic [RGB_W-1:0] BLANK_RGB = 12'h000;

  typedef enum logic [1:0] {
    TILE_SKY      = 2'd0,
    TILE_GROUND   = 2'd1,
    TILE_PLATFORM = 2'd2,
    TILE_RSVD     = 2'd3
  } tile_id_e;

  // Transparent ROM texels show the sky behind them.
  function automatic logic [RGB_W-1:0] key_out(
    input logic [RGB_W-1:0] c
  );
    return (c == KEY_RGB) ? SKY_RGB : c;
  endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Raster position counters for tile fetch: tx/col along a line, ty/row per line.
// Row bases are accumulated so no multiplier is needed (TILE_GRID_OVERLAY_EN adds on_grid).
module tile_pos_counter
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              pix_valid,
`ifdef TILE_GRID_OVERLAY_EN
  output logic              on_grid,
`endif
  output logic [ADDR_W-1:0] map_addr,
  output logic [ADDR_W-1:0] rom_addr
);

  localparam logic [POS_W-1:0] TX_LAST  = POS_W'(TILE_W - 1);
  localparam logic [POS_W-1:0] COL_LAST = POS_W'(MAP_COLS - 1);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(MAP_ROWS - 1);

  localparam logic [ADDR_W-1:0] ROM_STEP = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] MAP_STEP = ADDR_W'(MAP_COLS);

  logic [POS_W-1:0]  tx;
  logic [POS_W-1:0]  col;
  logic [POS_W-1:0]  ty;
  logic [POS_W-1:0]  row;
  logic [ADDR_W-1:0] rom_base;
  logic [ADDR_W-1:0] map_base;

  // Horizontal walk: tx wraps per tile, col saturates at the last map column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx  <= '0;
      col <= '0;
    end else if (frame_start || line_end) begin
      tx  <= '0;
      col <= '0;
    end else if (pix_valid) begin
      if (tx == TX_LAST) begin
        tx <= '0;
        if (col != COL_LAST) begin
          col <= col + 1'b1;
        end
      end else begin
        tx <= tx + 1'b1;
      end
    end
  end

  // Vertical walk with the ROM and map row-base accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ty       <= '0;
      row      <= '0;
      rom_base <= '0;
      map_base <= '0;
    end else if (frame_start) begin
      ty       <= '0;
      row      <= '0;
      rom_base <= '0;
      map_base <= '0;
    end else if (line_end) begin
      if (ty == TX_LAST) begin
        ty       <= '0;
        rom_base <= '0;
        if (row != ROW_LAST) begin
          row      <= row + 1'b1;
          map_base <= map_base + MAP_STEP;
        end
      end else begin
        ty       <= ty + 1'b1;
        rom_base <= rom_base + ROM_STEP;
      end
    end
  end

  assign rom_addr = rom_base + ADDR_W'(tx);
  assign map_addr = map_base + ADDR_W'(col);

`ifdef TILE_GRID_OVERLAY_EN
  assign on_grid = (tx == '0) || (ty == '0);
`endif

endmodule

// File: rtl/tile_pixel_fetch.sv
// Tile fetch initiator: issues map/ROM addresses, then muxes, keys and registers RGB.
// Build with TILE_GRID_OVERLAY_EN to paint tile borders white.
module tile_pixel_fetch
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [1:0]        map_tile_id,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  ground_data,
  input  logic [RGB_W-1:0]  platform_data,
  output logic [RGB_W-1:0]  rgb,
  output logic              rgb_valid
);

  logic             v1;
  logic             issue;
  tile_id_e         tile_id;
  logic [RGB_W-1:0] sel;
  logic [RGB_W-1:0] pix;

  // Only pixels not overridden by frame_start or line_end enter the pipe.
  assign issue = pix_valid && !line_end && !frame_start;

`ifdef TILE_GRID_OVERLAY_EN
  logic on_grid;
  logic grid1;

  tile_pos_counter u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_end    (line_end),
    .pix_valid   (pix_valid),
    .on_grid     (on_grid),
    .map_addr    (map_addr),
    .rom_addr    (rom_addr)
  );

  // Grid flag travels with the read so latency stays at two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid1 <= 1'b0;
    end else begin
      grid1 <= on_grid;
    end
  end
`else
  tile_pos_counter u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_end    (line_end),
    .pix_valid   (pix_valid),
    .map_addr    (map_addr),
    .rom_addr    (rom_addr)
  );
`endif

  assign tile_id = tile_id_e'(map_tile_id);

  // Pick the texel source by tile ID, then apply transparency keying.
  always_comb begin
    sel = SKY_RGB;
    unique case (1'b1)
      tile_id == TILE_GROUND:   sel = ground_data;
      tile_id == TILE_PLATFORM: sel = platform_data;
      default:                  sel = SKY_RGB;
    endcase
    pix = key_out(sel);
`ifdef TILE_GRID_OVERLAY_EN
    if (grid1) begin
      pix = GRID_RGB;
    end
`endif
  end

  // Stage 0 marks the read in flight; stage 1 registers the pixel or blanks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      rgb       <= BLANK_RGB;
      rgb_valid <= 1'b0;
    end else begin
      v1        <= issue;
      rgb_valid <= v1;
      rgb       <= v1 ? pix : BLANK_RGB;
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Directed bench for tile_pixel_fetch with synchronous RAM/ROM models.
// Expectations follow TILE_GRID_OVERLAY_EN when it is defined.
module tb_tile_pixel_fetch;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        line_end;
  logic        pix_valid;
  logic [9:0]  map_addr;
  logic [1:0]  map_tile_id;
  logic [9:0]  rom_addr;
  logic [11:0] ground_data;
  logic [11:0] platform_data;
  logic [11:0] rgb;
  logic        rgb_valid;

  logic [1:0]  map_mem [0:1023];
  logic [11:0] gnd_mem [0:1023];
  logic [11:0] plt_mem [0:1023];

  int checks;
  int fails;

  tile_pixel_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .line_end      (line_end),
    .pix_valid     (pix_valid),
    .map_addr      (map_addr),
    .map_tile_id   (map_tile_id),
    .rom_addr      (rom_addr),
    .ground_data   (ground_data),
    .platform_data (platform_data),
    .rgb           (rgb),
    .rgb_valid     (rgb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    map_tile_id   <= map_mem[map_addr];
    ground_data   <= gnd_mem[rom_addr];
    platform_data <= plt_mem[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ov(input logic [11:0] c, input bit edge_px);
`ifdef TILE_GRID_OVERLAY_EN
    return edge_px ? 12'hFFF : c;
`else
    return edge_px ? c : c;
`endif
  endfunction

  function automatic logic [11:0] wrap_exp(input int i);
    logic [11:0] c;
    if (i == 24)      c = 12'h6BF;
    else if (i == 5)  c = 12'h6BF;
    else if (i == 0)  c = 12'h841;
    else              c = 12'h200 + 12'(i);
    return ov(c, 1'b1);
  endfunction

  initial begin
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    line_end = 1'b0;
    pix_valid = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      map_mem[i] = 2'd0;
      gnd_mem[i] = 12'h000;
      plt_mem[i] = 12'h000;
    end
    map_mem[0] = 2'd1;
    map_mem[1] = 2'd3;
    for (int i = 1; i < 24; i++) gnd_mem[i] = 12'h200 + 12'(i);
    gnd_mem[0] = 12'h841;
    gnd_mem[5] = 12'hF0F;
    plt_mem[0] = 12'h0C3;
    map_mem[27] = 2'd2;
    plt_mem[120] = 12'hF0F;
    gnd_mem[120] = 12'h777;
    plt_mem[121] = 12'hABC;
    gnd_mem[121] = 12'h456;

    step();
    step();
    chk("rst_rgb", 32'(rgb), 32'h000);
    chk("rst_valid", 32'(rgb_valid), 32'h0);
    chk("rst_map", 32'(map_addr), 32'h0);
    chk("rst_rom", 32'(rom_addr), 32'h0);
    rst_n = 1'b1;
    step();

    // single pixel latency
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    chk("lat_rom", 32'(rom_addr), 32'h0);
    chk("lat_map", 32'(map_addr), 32'h0);
    step();
    pix_valid = 1'b0;
    chk("lat_t1_valid", 32'(rgb_valid), 32'h0);
    step();
    chk("lat_t2_valid", 32'(rgb_valid), 32'h1);
    chk("lat_t2_rgb", 32'(rgb), 32'(ov(12'h841, 1'b1)));
    step();
    chk("lat_t3_valid", 32'(rgb_valid), 32'h0);
    chk("lat_t3_blank", 32'(rgb), 32'h000);

    // tile wrap on line 0 with keying and reserved ID
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 27; i++) begin
      pix_valid = (i < 25);
      if (i < 25) begin
        chk("wrap_rom", 32'(rom_addr), (i < 24) ? 32'(i) : 32'h0);
        chk("wrap_map", 32'(map_addr), (i < 24) ? 32'h0 : 32'h1);
      end
      if (i >= 2) begin
        chk("wrap_valid", 32'(rgb_valid), 32'h1);
        chk("wrap_rgb", 32'(rgb), 32'(wrap_exp(i - 2)));
      end
      step();
    end
    chk("wrap_end_valid", 32'(rgb_valid), 32'h0);

    // vertical: 24 lines to map row 1
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      line_end = 1'b1;
      step();
    end
    line_end = 1'b0;
    pix_valid = 1'b1;
    chk("row1_rom", 32'(rom_addr), 32'h0);
    chk("row1_map", 32'(map_addr), 32'd27);
    step();
    pix_valid = 1'b0;
    step();
    chk("row1_valid", 32'(rgb_valid), 32'h1);
    chk("row1_plat", 32'(rgb), 32'(ov(12'h0C3, 1'b1)));
    for (int i = 0; i < 5; i++) begin
      line_end = 1'b1;
      step();
    end
    line_end = 1'b0;
    pix_valid = 1'b1;
    chk("ty5_rom0", 32'(rom_addr), 32'd120);
    chk("ty5_map0", 32'(map_addr), 32'd27);
    step();
    chk("ty5_rom1", 32'(rom_addr), 32'd121);
    step();
    pix_valid = 1'b0;
    chk("key_valid", 32'(rgb_valid), 32'h1);
    chk("key_plat", 32'(rgb), 32'(ov(12'h6BF, 1'b1)));
    step();
    chk("plat_valid", 32'(rgb_valid), 32'h1);
    chk("plat_rgb", 32'(rgb), 32'hABC);

    // line_end wins over pix_valid
    pix_valid = 1'b1;
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    pix_valid = 1'b0;
    chk("le_tx_hold", 32'(rom_addr), 32'd144);
    step();
    chk("le_drop", 32'(rgb_valid), 32'h0);

    // frame_start wins over line_end and pix_valid
    frame_start = 1'b1;
    line_end = 1'b1;
    pix_valid = 1'b1;
    step();
    frame_start = 1'b0;
    line_end = 1'b0;
    pix_valid = 1'b0;
    chk("fs_rom", 32'(rom_addr), 32'h0);
    chk("fs_map", 32'(map_addr), 32'h0);
    step();
    chk("fs_drop", 32'(rgb_valid), 32'h0);

    // column saturation across a 700 pixel line
    pix_valid = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if (i == 648) chk("sat_map_648", 32'(map_addr), 32'd26);
      if (i == 699) begin
        chk("sat_map_699", 32'(map_addr), 32'd26);
        chk("sat_rom_699", 32'(rom_addr), 32'd3);
      end
      step();
    end
    pix_valid = 1'b0;
    step();
    step();

    // asynchronous reset in mid stream
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    step();
    step();
    chk("pre_rst_valid", 32'(rgb_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb), 32'h000);
    chk("arst_valid", 32'(rgb_valid), 32'h0);
    pix_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("drop_valid0", 32'(rgb_valid), 32'h0);
    step();
    chk("drop_valid1", 32'(rgb_valid), 32'h0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    chk("post_rst_rom", 32'(rom_addr), 32'h0);
    chk("post_rst_map", 32'(map_addr), 32'h0);
    step();
    pix_valid = 1'b0;
    step();
    chk("post_rst_valid", 32'(rgb_valid), 32'h1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
